// File: rtl/down_timer.sv
// ---------------------------------------------------------------------------
// down_timer
//   Loadable down-counting timer. Holds a reload value, counts it down to
//   zero while enabled, pulses o_tc for one cycle on expiry and optionally
//   reloads itself to produce periodic strobes.
//
// Ports
//   i_clk          system clock, rising edge
//   i_rst          synchronous active-high reset
//   i_load         capture i_data into reload register and counter, abort run
//   i_data         value captured on i_load
//   i_start        start countdown from current counter (IDLE only)
//   i_en           count enable; low pauses the countdown in RUN
//   i_auto_reload  1 = reload and restart after expiry, 0 = one-shot
//   o_counter      current count (registered)
//   o_busy         high while in RUN or EXPIRED (registered)
//   o_tc           terminal-count pulse, high exactly while EXPIRED
// ---------------------------------------------------------------------------
module down_timer #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_start,
    input  logic             i_en,
    input  logic             i_auto_reload,
    output logic [WIDTH-1:0] o_counter,
    output logic             o_busy,
    output logic             o_tc
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO = '0;

    state_t           state;
    logic [WIDTH-1:0] reload;

    // o_busy and o_tc are registered alongside the state so they are pure
    // flop outputs that always agree with the state entered on this edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            reload    <= ZERO;
            o_counter <= ZERO;
            o_busy    <= 1'b0;
            o_tc      <= 1'b0;
        end else if (i_load) begin
            state     <= IDLE;
            reload    <= i_data;
            o_counter <= i_data;
            o_busy    <= 1'b0;
            o_tc      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        o_busy <= 1'b1;
                        if (o_counter == ZERO) begin
                            // Nothing to count: expire straight away.
                            state <= EXPIRED;
                            o_tc  <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (i_en) begin
                        // Counter is never 0 in RUN; <= ONE keeps it from
                        // wrapping even if that ever stopped being true.
                        if (o_counter <= ONE) begin
                            o_counter <= ZERO;
                            state     <= EXPIRED;
                            o_tc      <= 1'b1;
                        end else begin
                            o_counter <= o_counter - ONE;
                        end
                    end
                end
                EXPIRED: begin
                    // Single cycle regardless of i_en.
                    o_tc <= 1'b0;
                    if (i_auto_reload && (reload != ZERO)) begin
                        o_counter <= reload;
                        state     <= RUN;
                    end else begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                    o_tc   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_down_timer.sv
module tb_down_timer;

    localparam int WIDTH = 4;

    logic             i_clk = 1'b0;
    logic             i_rst = 1'b1;
    logic             i_load = 1'b0;
    logic [WIDTH-1:0] i_data = '0;
    logic             i_start = 1'b0;
    logic             i_en = 1'b0;
    logic             i_auto_reload = 1'b0;
    logic [WIDTH-1:0] o_counter;
    logic             o_busy;
    logic             o_tc;

    int errors = 0;
    int checks = 0;

    // Reference model: busy/expired flags plus count and reload value.
    logic [WIDTH-1:0] m_cnt = '0;
    logic [WIDTH-1:0] m_rel = '0;
    logic             m_busy = 1'b0;
    logic             m_tc = 1'b0;

    down_timer #(.WIDTH(WIDTH)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_load       (i_load),
        .i_data       (i_data),
        .i_start      (i_start),
        .i_en         (i_en),
        .i_auto_reload(i_auto_reload),
        .o_counter    (o_counter),
        .o_busy       (o_busy),
        .o_tc         (o_tc)
    );

    always #5 i_clk = ~i_clk;

    // Next-state of the model from the inputs present before the edge.
    task automatic model_step();
        if (i_rst) begin
            m_cnt = '0; m_rel = '0; m_busy = 0; m_tc = 0;
        end else if (i_load) begin
            m_cnt = i_data; m_rel = i_data; m_busy = 0; m_tc = 0;
        end else if (m_tc) begin
            m_tc = 0;
            if (i_auto_reload && m_rel != 0) m_cnt = m_rel;
            else m_busy = 0;
        end else if (m_busy) begin
            if (i_en && m_cnt != 0) begin
                m_cnt = m_cnt - 1'b1;
                if (m_cnt == 0) m_tc = 1;
            end
        end else if (i_start) begin
            m_busy = 1;
            if (m_cnt == 0) m_tc = 1;
        end
    endtask

    task automatic cyc();
        model_step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_rst = 0; i_load = 0; i_start = 0; i_en = 1; i_auto_reload = 0;
    endtask

    task automatic load_val(input logic [WIDTH-1:0] v);
        i_load = 1; i_data = v; cyc(); i_load = 0;
    endtask

    task automatic test_reset();
        i_rst = 1; i_load = 1; i_data = 4'd9;
        for (int k = 0; k < 2; k++) begin
            cyc();
            checks++;
            if (o_counter !== 4'd0 || o_busy !== 1'b0 || o_tc !== 1'b0) begin
                errors++;
                $display("FAIL reset cyc%0d: got cnt=%0d busy=%b tc=%b, want 0/0/0",
                         k, o_counter, o_busy, o_tc);
            end
        end
        idle_inputs();
    endtask

    task automatic test_one_shot();
        int tc_n = 0, tc_at = -1;
        load_val(4'd9);
        checks++;
        if (o_counter !== 4'd9 || o_busy !== 1'b0) begin
            errors++; $display("FAIL oneshot_load: got cnt=%0d busy=%b, want 9/0", o_counter, o_busy);
        end
        i_start = 1; cyc(); i_start = 0;
        checks++;
        if (o_counter !== 4'd9 || o_busy !== 1'b1) begin
            errors++; $display("FAIL oneshot_start: got cnt=%0d busy=%b, want 9/1", o_counter, o_busy);
        end
        for (int t = 2; t <= 12; t++) begin
            cyc();
            if (o_tc) begin tc_n++; tc_at = t; end
            checks++;
            if (o_counter !== m_cnt || o_tc !== m_tc || o_busy !== m_busy) begin
                errors++; $display("FAIL oneshot_seq t%0d: got cnt=%0d tc=%b busy=%b, want %0d/%b/%b",
                                   t, o_counter, o_tc, o_busy, m_cnt, m_tc, m_busy);
            end
        end
        checks++;
        if (tc_n != 1 || tc_at != 10) begin
            errors++; $display("FAIL oneshot_tc: got %0d pulses at t%0d, want 1 at t10", tc_n, tc_at);
        end
        checks++;
        if (o_busy !== 1'b0 || o_counter !== 4'd0) begin
            errors++; $display("FAIL oneshot_end: got busy=%b cnt=%0d, want 0/0", o_busy, o_counter);
        end
    endtask

    task automatic test_pause();
        int t = 1, tc_at = -1;
        load_val(4'd5);
        i_start = 1; cyc(); i_start = 0;
        while (o_counter !== 4'd3 && t < 20) begin cyc(); t++; end
        for (int k = 0; k < 3; k++) begin
            i_en = 0; cyc(); t++;
            checks++;
            if (o_counter !== 4'd3 || o_busy !== 1'b1) begin
                errors++; $display("FAIL pause_hold k%0d: got cnt=%0d busy=%b, want 3/1", k, o_counter, o_busy);
            end
        end
        i_en = 1;
        while (tc_at < 0 && t < 30) begin
            cyc(); t++;
            if (o_tc) tc_at = t;
        end
        // Unpaused expiry is 6 cycles after start; pause adds 3.
        checks++;
        if (tc_at != 9) begin
            errors++; $display("FAIL pause_tc: got tc at t%0d, want t9", tc_at);
        end
        cyc();
    endtask

    task automatic test_auto_reload();
        logic [WIDTH-1:0] exp_seq [12] = '{3,2,1,0,3,2,1,0,3,2,1,0};
        load_val(4'd3);
        i_auto_reload = 1; i_start = 1; cyc(); i_start = 0;
        for (int t = 1; t <= 12; t++) begin
            if (t > 1) cyc();
            checks++;
            if (o_counter !== exp_seq[t-1] || o_tc !== (t % 4 == 0)) begin
                errors++; $display("FAIL auto_seq t%0d: got cnt=%0d tc=%b, want %0d/%b",
                                   t, o_counter, o_tc, exp_seq[t-1], (t % 4 == 0));
            end
        end
        cyc();
        i_auto_reload = 0;
        cyc(); cyc(); cyc();
        checks++;
        if (o_tc !== 1'b1 || o_counter !== 4'd0) begin
            errors++; $display("FAIL auto_last_tc: got tc=%b cnt=%0d, want 1/0", o_tc, o_counter);
        end
        cyc();
        checks++;
        if (o_busy !== 1'b0 || o_tc !== 1'b0 || o_counter !== 4'd0) begin
            errors++; $display("FAIL auto_stop: got busy=%b tc=%b cnt=%0d, want 0/0/0", o_busy, o_tc, o_counter);
        end
    endtask

    task automatic test_abort_zero();
        int t = 0, tc_n = 0;
        load_val(4'd7);
        i_start = 1; cyc(); i_start = 0;
        while (o_counter !== 4'd4 && t < 20) begin cyc(); t++; end
        load_val(4'd2);
        checks++;
        if (o_counter !== 4'd2 || o_busy !== 1'b0 || o_tc !== 1'b0) begin
            errors++; $display("FAIL abort: got cnt=%0d busy=%b tc=%b, want 2/0/0", o_counter, o_busy, o_tc);
        end
        for (int k = 0; k < 5; k++) begin cyc(); if (o_tc) tc_n++; end
        checks++;
        if (tc_n != 0 || o_counter !== 4'd2) begin
            errors++; $display("FAIL abort_quiet: got %0d pulses cnt=%0d, want 0/2", tc_n, o_counter);
        end
        load_val(4'd0);
        i_start = 1; cyc(); i_start = 0;
        checks++;
        if (o_tc !== 1'b1 || o_busy !== 1'b1 || o_counter !== 4'd0) begin
            errors++; $display("FAIL zero_start: got tc=%b busy=%b cnt=%0d, want 1/1/0", o_tc, o_busy, o_counter);
        end
        cyc();
        checks++;
        if (o_tc !== 1'b0 || o_busy !== 1'b0) begin
            errors++; $display("FAIL zero_end: got tc=%b busy=%b, want 0/0", o_tc, o_busy);
        end
    endtask

    task automatic test_start_ignored();
        int tc_n = 0, tc_at = -1;
        load_val(4'd6);
        i_start = 1; cyc(); i_start = 0;
        for (int t = 2; t <= 12; t++) begin
            i_start = (o_counter == 4'd3);
            cyc();
            i_start = 0;
            if (o_tc) begin tc_n++; tc_at = t; end
        end
        checks++;
        if (tc_n != 1 || tc_at != 7) begin
            errors++; $display("FAIL start_ignored: got %0d pulses at t%0d, want 1 at t7", tc_n, tc_at);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            i_rst         = ($urandom_range(0, 99) < 2);
            i_load        = ($urandom_range(0, 99) < 8);
            i_data        = WIDTH'($urandom_range(0, 15));
            i_start       = ($urandom_range(0, 99) < 30);
            i_en          = ($urandom_range(0, 99) < 75);
            i_auto_reload = ($urandom_range(0, 99) < 50);
            cyc();
            checks++;
            if (o_counter !== m_cnt || o_busy !== m_busy || o_tc !== m_tc) begin
                errors++; $display("FAIL random k%0d: got cnt=%0d busy=%b tc=%b, want %0d/%b/%b",
                                   k, o_counter, o_busy, o_tc, m_cnt, m_busy, m_tc);
            end
        end
        idle_inputs();
    endtask

    initial begin
        #1;
        test_reset();
        test_one_shot();
        test_pause();
        test_auto_reload();
        test_abort_zero();
        test_start_ignored();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
